pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters:
- REG_AW, default 5, register-address width.
- LOAD_LAT, default 1, range 1..3, extra cycles a load result is unavailable after it leaves EXE.
- CNT_W, default 32, width of the performance counters.

REQ-002 Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a live instruction.
- id_rs, id_rt  in  REG_AW  ID source register addresses.
- id_rs_used, id_rt_used  in  1  the source operand is actually read.
- id_dst  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_branch_taken  in  1  branch or jump resolved taken in ID.
- mem_busy  in  1  MEM stage memory access not yet complete.
- stall_if, stall_id, stall_exe, stall_mem  out  1  hold the stage register.
- flush_id, bubble_exe, bubble_wb  out  1  insert a NOP into the stage register.
- fwd_a_sel, fwd_b_sel  out  2  operand source: 0 regfile, 1 EXE/MEM result, 2 MEM/WB result.
- stall_cycles, flush_count  out  CNT_W  performance counters.

Function
REQ-003 The block SHALL hold a scoreboard of {valid, reg_write, mem_read, dst, ld_cnt} for each of the EXE, MEM and WB slots.
REQ-004 A slot hazards on register r only if valid && reg_write && dst==r && r!=0; register 0 SHALL never cause a stall or a forward.
REQ-005 Load-use stall condition:
- True when the EXE slot is a load and hazards on a used ID source, or
- True when the MEM slot has mem_read && ld_cnt>0 and hazards on a used ID source.
REQ-006 On a load-use stall, stall_if=stall_id=1 and bubble_exe=1; the ID instruction SHALL be re-evaluated every cycle until the condition clears.
REQ-007 On entry to MEM, a load's ld_cnt SHALL be loaded with LOAD_LAT-1. ld_cnt SHALL decrement each cycle mem_busy=0 and saturate at 0.
REQ-008 Forward select, evaluated separately for rs and rt:
- 1 if the EXE slot hazards and is not a load.
- Otherwise 2 if the MEM slot hazards with ld_cnt==0.
- Otherwise 0.
REQ-009 mem_busy=1 SHALL assert stall_if, stall_id, stall_exe and stall_mem, and assert bubble_wb. The scoreboard SHALL not advance except that the WB slot is invalidated.
REQ-010 id_branch_taken with id_valid SHALL assert flush_id for one cycle, only when neither a load-use stall nor mem_busy is active; otherwise it is ignored that cycle.
REQ-011 Priority SHALL be mem_busy, then load-use stall, then flush, then normal advance.
REQ-012 Normal advance SHALL shift the slots ID→EXE→MEM→WB; the EXE slot takes the ID fields gated by id_valid.
REQ-013 A bubble SHALL load a slot with valid=0 and all other fields 0.
REQ-014 All stall, flush and bubble outputs SHALL be combinational from current inputs and scoreboard state, with zero-cycle latency.
REQ-015 stall_cycles SHALL increment every cycle stall_id=1. flush_count SHALL increment every cycle flush_id=1. Both SHALL saturate at all-ones, never wrapping.
REQ-016 When mem_busy and a load-use condition coincide, only the mem_busy response SHALL apply, and stall_cycles SHALL increment once.

Reset
REQ-017 While rstn=0:
- All scoreboard slots invalid and both counters 0.
- All stall, flush and bubble outputs 0.
- fwd_a_sel=fwd_b_sel=0.
REQ-018 Reset asserted mid-stall SHALL clear the stall immediately (asynchronously), and no state SHALL survive it.
REQ-019 The first valid ID instruction after reset release SHALL see no hazards.

Verification
REQ-020 Sequence `add r3,...` then `sub r4,r3,r5` → fwd_a_sel=1 on the sub cycle, no stall, stall_cycles=0.
REQ-021 Sequence `lw r2` then `add r6,r2,r1` with LOAD_LAT=1 → one cycle of stall_id=1 plus bubble_exe=1, then fwd_a_sel=2; stall_cycles=1.
REQ-022 Same sequence with LOAD_LAT=3 → three stall cycles, then fwd_a_sel=2; stall_cycles=3.
REQ-023 mem_busy held 4 cycles during a load-use stall → stall_mem=1 for 4 cycles, bubble_wb=1 for 4 cycles, stall_cycles incremented once per cycle (not twice).
REQ-024 Writes to r0 followed by reads of r0 → fwd_*_sel=0 and no stall; a taken branch with no hazard → flush_id=1 for one cycle and flush_count=1.
REQ-025 rstn driven low for one cycle during a stall → all outputs 0 within the reset cycle; counters at all-ones stay at all-ones when incremented again.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks EXE/MEM/WB producers and
// generates load-use stalls, memory-wait stalls, branch flushes and forwarding selects.
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_branch_taken,
   input  logic              mem_busy,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_exe,
   output logic              stall_mem,
   output logic              flush_id,
   output logic              bubble_exe,
   output logic              bubble_wb,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic [REG_AW-1:0] dst;
      logic [1:0]        ld_cnt;
   } slot_t;

   localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

   slot_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
   slot_t id_slot, exe_to_mem, mem_dec;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic use_a, use_b, exe_hit, mem_hit, mem_pend, busy, load_use;

   function automatic logic hazard(input slot_t s, input logic [REG_AW-1:0] r);
      return s.valid && s.reg_write && (s.dst == r) && (r != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] r,
                                          input slot_t e, input slot_t m);
      if (used && hazard(e, r) && !e.mem_read)
         return 2'd1;
      else if (used && hazard(m, r) && (m.ld_cnt == 2'd0))
         return 2'd2;
      else
         return 2'd0;
   endfunction

   always_comb begin
      use_a    = id_valid & id_rs_used;
      use_b    = id_valid & id_rt_used;
      exe_hit  = (use_a & hazard(exe_q, id_rs)) | (use_b & hazard(exe_q, id_rt));
      mem_hit  = (use_a & hazard(mem_q, id_rs)) | (use_b & hazard(mem_q, id_rt));
      mem_pend = mem_q.mem_read & (mem_q.ld_cnt != 2'd0);
      busy     = rstn & mem_busy;
      load_use = (exe_q.mem_read & exe_hit) | (mem_pend & mem_hit);

      stall_exe  = busy;
      stall_mem  = busy;
      bubble_wb  = busy;
      stall_if   = busy | load_use;
      stall_id   = busy | load_use;
      bubble_exe = ~busy & load_use;
      flush_id   = rstn & ~busy & ~load_use & id_valid & id_branch_taken;
      fwd_a_sel  = fwd_sel(use_a, id_rs, exe_q, mem_q);
      fwd_b_sel  = fwd_sel(use_b, id_rt, exe_q, mem_q);
   end

   always_comb begin
      id_slot           = '0;
      id_slot.valid     = id_valid;
      id_slot.reg_write = id_valid & id_reg_write;
      id_slot.mem_read  = id_valid & id_mem_read;
      id_slot.dst       = id_valid ? id_dst : '0;

      exe_to_mem        = exe_q;
      exe_to_mem.ld_cnt = exe_q.mem_read ? LD_INIT : 2'd0;

      mem_dec           = mem_q;
      if (mem_q.ld_cnt != 2'd0)
         mem_dec.ld_cnt = mem_q.ld_cnt - 2'd1;

      exe_d = exe_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (busy) begin
         wb_d = '0;
      end else if (load_use) begin
         exe_d = '0;
         // A load still waiting on its latency stays in MEM so it keeps guarding its consumer.
         if (mem_pend) begin
            mem_d = mem_dec;
            wb_d  = '0;
         end else begin
            mem_d = exe_to_mem;
            wb_d  = mem_dec;
         end
      end else begin
         exe_d = id_slot;
         mem_d = exe_to_mem;
         wb_d  = mem_dec;
      end

      stall_cycles_d = stall_cycles_q;
      if (stall_id && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      flush_count_d = flush_count_q;
      if (flush_id && (flush_count_q != '1))
         flush_count_d = flush_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exe_q          <= '0;
         mem_q          <= '0;
         wb_q           <= '0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         exe_q          <= exe_d;
         mem_q          <= mem_d;
         wb_q           <= wb_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1 and 3) share stimulus and are
// compared against an abstract pipeline model through expected-response queues.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
   logic       id_branch_taken, mem_busy;
   logic [4:0] id_rs, id_rt, id_dst;

   logic       si0, sd0, se0, sm0, fl0, be0, bw0;
   logic       si1, sd1, se1, sm1, fl1, be1, bw1;
   logic [1:0] fa0, fb0, fa1, fb1;
   logic [3:0] sc0, fc0, sc1, fc1;
   logic [10:0] obs0, obs1;

   assign obs0 = {si0, sd0, se0, sm0, fl0, be0, bw0, fa0, fb0};
   assign obs1 = {si1, sd1, se1, sm1, fl1, be1, bw1, fa1, fb1};

   pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_l1 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
      .stall_if(si0), .stall_id(sd0), .stall_exe(se0), .stall_mem(sm0),
      .flush_id(fl0), .bubble_exe(be0), .bubble_wb(bw0),
      .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cycles(sc0), .flush_count(fc0));

   pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_l3 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
      .stall_if(si1), .stall_id(sd1), .stall_exe(se1), .stall_mem(sm1),
      .flush_id(fl1), .bubble_exe(be1), .bubble_wb(bw1),
      .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cycles(sc1), .flush_count(fc1));

   typedef struct {
      bit v;
      bit rw;
      bit mr;
      int dst;
      int ld;
   } mslot_t;

   typedef struct {
      logic [10:0] o;
      int          sc;
      int          fc;
   } exp_t;

   // model pipeline per instance: index 0 = EXE, 1 = MEM, 2 = WB
   mslot_t ms [2][3];
   int     m_sc [2];
   int     m_fc [2];
   exp_t   q0 [$];
   exp_t   q1 [$];
   int     errors = 0;
   int     checks = 0;
   bit     done   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mhaz(input mslot_t s, input int r);
      return s.v && s.rw && (s.dst == r) && (r != 0);
   endfunction

   function automatic int fsel(input mslot_t e, input mslot_t m, input bit u, input int r);
      if (!u) return 0;
      if (mhaz(e, r) && !e.mr) return 1;
      if (mhaz(m, r) && m.ld == 0) return 2;
      return 0;
   endfunction

   task automatic model_cycle(input int k, input int lat, output exp_t e);
      mslot_t E, M, W, empty;
      bit ua, ub, lu, busy, stall, fl;
      int rs, rt, fa, fb;
      empty = '{default: 0};
      E = ms[k][0]; M = ms[k][1]; W = ms[k][2];
      if (!rstn) begin
         ms[k][0] = empty; ms[k][1] = empty; ms[k][2] = empty;
         m_sc[k] = 0; m_fc[k] = 0;
         e.o = '0; e.sc = 0; e.fc = 0;
         return;
      end
      rs = int'(id_rs); rt = int'(id_rt);
      ua = id_valid && id_rs_used;
      ub = id_valid && id_rt_used;
      lu = (E.mr && ((ua && mhaz(E, rs)) || (ub && mhaz(E, rt)))) ||
           (M.mr && M.ld > 0 && ((ua && mhaz(M, rs)) || (ub && mhaz(M, rt))));
      busy  = mem_busy;
      stall = busy || lu;
      fl    = !busy && !lu && id_valid && id_branch_taken;
      fa    = fsel(E, M, ua, rs);
      fb    = fsel(E, M, ub, rt);
      e.o   = {stall, stall, busy, busy, fl, (!busy && lu), busy, 2'(fa), 2'(fb)};
      e.sc  = m_sc[k];
      e.fc  = m_fc[k];
      if (stall && m_sc[k] < 15) m_sc[k]++;
      if (fl && m_fc[k] < 15) m_fc[k]++;
      if (busy) begin
         W = empty;
      end else if (lu) begin
         if (M.mr && M.ld > 0) begin
            M.ld--;
            W = empty;
         end else begin
            W = M;
            M = E;
            M.ld = M.mr ? lat - 1 : 0;
         end
         E = empty;
      end else begin
         W = M;
         M = E;
         M.ld = M.mr ? lat - 1 : 0;
         if (id_valid) E = '{1'b1, id_reg_write, id_mem_read, int'(id_dst), 0};
         else          E = empty;
      end
      ms[k][0] = E; ms[k][1] = M; ms[k][2] = W;
   endtask

   task automatic drive(input bit rn, input bit v, input int rs, input bit ru, input int rt,
                        input bit tu, input int dst, input bit rw, input bit mr,
                        input bit br, input bit busy);
      exp_t e;
      @(posedge clk);
      #1;
      rstn = rn; id_valid = v; id_rs = 5'(rs); id_rs_used = ru; id_rt = 5'(rt);
      id_rt_used = tu; id_dst = 5'(dst); id_reg_write = rw; id_mem_read = mr;
      id_branch_taken = br; mem_busy = busy;
      model_cycle(0, 1, e); q0.push_back(e);
      model_cycle(1, 3, e); q1.push_back(e);
   endtask

   task automatic nop(input bit busy);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // monitor: pop one expected record per instance each cycle
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("l1_outputs", int'(obs0), int'(e.o));
            chk("l1_stall_cycles", int'(sc0), e.sc);
            chk("l1_flush_count", int'(fc0), e.fc);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("l3_outputs", int'(obs1), int'(e.o));
            chk("l3_stall_cycles", int'(sc1), e.sc);
            chk("l3_flush_count", int'(fc1), e.fc);
         end
      end
   end

   initial begin
      rstn = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
      id_rt_used = 1'b0; id_dst = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      id_branch_taken = 1'b0; mem_busy = 1'b0;
      repeat (2) do_reset();

      // ALU producer then consumer: forward from EXE, no stall
      drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
      drive(1, 1, 3, 1, 5, 1, 4, 1, 0, 0, 0);
      @(negedge clk);
      chk("alu_fwd_a_l1", int'(fa0), 1);
      chk("alu_fwd_a_l3", int'(fa1), 1);
      chk("alu_no_stall", int'(sd0), 0);
      repeat (3) nop(0);

      // load then dependent add, add held in ID across the stall
      drive(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      repeat (5) drive(1, 1, 2, 1, 1, 1, 6, 1, 0, 0, 0);
      @(negedge clk);
      chk("load_use_stalls_l1", int'(sc0), 1);
      chk("load_use_stalls_l3", int'(sc1), 3);
      repeat (3) nop(0);

      // mem_busy for 4 cycles during a load-use stall
      do_reset();
      drive(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      repeat (4) drive(1, 1, 2, 1, 1, 1, 6, 1, 0, 0, 1);
      repeat (4) drive(1, 1, 2, 1, 1, 1, 6, 1, 0, 0, 0);
      @(negedge clk);
      chk("busy_stalls_l1", int'(sc0), 5);
      chk("busy_stalls_l3", int'(sc1), 7);

      // r0 never hazards; taken branch with no hazard flushes once
      do_reset();
      drive(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      drive(1, 1, 7, 1, 8, 1, 9, 0, 0, 1, 0);
      nop(0);
      @(negedge clk);
      chk("r0_no_stall", int'(sc0), 0);
      chk("branch_flush_count", int'(fc0), 1);

      // reset in the middle of a stall, then counter saturation
      drive(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      drive(1, 1, 2, 1, 1, 1, 6, 1, 0, 0, 1);
      drive(0, 1, 2, 1, 1, 1, 6, 1, 0, 0, 1);
      @(negedge clk);
      chk("reset_mid_stall_l3", int'(obs1), 0);
      repeat (20) nop(1);
      repeat (20) drive(1, 1, 7, 1, 8, 1, 9, 0, 0, 1, 0);
      nop(0);
      @(negedge clk);
      chk("stall_cycles_sat", int'(sc1), 15);
      chk("flush_count_sat", int'(fc0), 15);

      // randomized traffic with a small register pool to provoke hazards
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 6) == 0));
      end
      repeat (3) @(negedge clk);
      chk("queues_drained", q0.size() + q1.size(), 0);
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
